// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier sequencer that borrows the shared ALU adder.
// Optional MULHU (upper half) support is enabled by defining MULHU_EN.
module alu_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start_EX,
    input  logic [1:0]       i_op_EX,
    input  logic [WIDTH-1:0] i_rs1_EX,
    input  logic [WIDTH-1:0] i_rs2_EX,
    input  logic             i_flush_EX,
    input  logic [WIDTH-1:0] i_alu_result_EX,
    output logic [4:0]       o_alu_ctrl_EX,
    output logic [WIDTH-1:0] o_alu_a_EX,
    output logic [WIDTH-1:0] o_alu_b_EX,
    output logic             o_alu_own_EX,
    output logic             o_stall_EX,
    output logic             o_done_EX,
    output logic [WIDTH-1:0] o_result_EX
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_hi;
    logic [CW-1:0]    cnt;
    logic             legal;
    logic             load;
    logic             bad;
    logic             step;
    logic             last;
    logic             carry;
    logic [WIDTH-1:0] acc_hi_n;
    logic [WIDTH-1:0] mplier_n;
    logic [WIDTH-1:0] fin;

`ifdef MULHU_EN
    logic             op_hi;
    assign legal = (i_op_EX == 2'b00) || (i_op_EX == 2'b01);
    assign fin   = op_hi ? acc_hi_n : mplier_n;
`else
    assign legal = (i_op_EX == 2'b00);
    assign fin   = mplier_n;
`endif

    // One accumulate step; the ALU has no carry-out, so recover it by compare.
    always_comb begin
        carry    = i_alu_result_EX < o_alu_a_EX;
        acc_hi_n = {carry, i_alu_result_EX[WIDTH-1:1]};
        mplier_n = {i_alu_result_EX[0], mplier[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state decode; flush dominates terminal count and start.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        bad     = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start_EX && !i_flush_EX) begin
                    if (legal) begin
                        load    = 1'b1;
                        state_n = RUN;
                    end else begin
                        bad     = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                if (i_flush_EX) begin
                    state_n = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == LAST) begin
                        last    = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, shift-accumulate and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mcand       <= '0;
            mplier      <= '0;
            acc_hi      <= '0;
            cnt         <= '0;
            o_result_EX <= '0;
`ifdef MULHU_EN
            op_hi       <= 1'b0;
`endif
        end else begin
            if (load) begin
                mcand  <= i_rs1_EX;
                mplier <= i_rs2_EX;
                acc_hi <= '0;
                cnt    <= '0;
`ifdef MULHU_EN
                op_hi  <= i_op_EX[0];
`endif
            end
            if (step) begin
                acc_hi <= acc_hi_n;
                mplier <= mplier_n;
                cnt    <= cnt + 1'b1;
            end
            if (bad)  o_result_EX <= '0;
            if (last) o_result_EX <= fin;
        end
    end

    // Moore ALU hand-over and stall decode.
    always_comb begin
        o_alu_own_EX  = (state == RUN);
        o_stall_EX    = (state == RUN) || (state == DONE);
        o_alu_ctrl_EX = o_alu_own_EX ? ALU_ADD : 5'b00000;
        o_alu_a_EX    = o_alu_own_EX ? acc_hi : '0;
        o_alu_b_EX    = (o_alu_own_EX && mplier[0]) ? mcand : '0;
        o_done_EX     = (state == DONE) && !i_flush_EX;
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural shared ALU.
// Expected values are hand-computed; MULHU_EN selects the MULHU vectors.
module tb_alu_mul_sequencer;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start_EX;
    logic [1:0]  i_op_EX;
    logic [31:0] i_rs1_EX;
    logic [31:0] i_rs2_EX;
    logic        i_flush_EX;
    logic [31:0] i_alu_result_EX;
    logic [4:0]  o_alu_ctrl_EX;
    logic [31:0] o_alu_a_EX;
    logic [31:0] o_alu_b_EX;
    logic        o_alu_own_EX;
    logic        o_stall_EX;
    logic        o_done_EX;
    logic [31:0] o_result_EX;

    int n_chk;
    int n_ok;

    alu_mul_sequencer #(.WIDTH(32)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start_EX     (i_start_EX),
        .i_op_EX        (i_op_EX),
        .i_rs1_EX       (i_rs1_EX),
        .i_rs2_EX       (i_rs2_EX),
        .i_flush_EX     (i_flush_EX),
        .i_alu_result_EX(i_alu_result_EX),
        .o_alu_ctrl_EX  (o_alu_ctrl_EX),
        .o_alu_a_EX     (o_alu_a_EX),
        .o_alu_b_EX     (o_alu_b_EX),
        .o_alu_own_EX   (o_alu_own_EX),
        .o_stall_EX     (o_stall_EX),
        .o_done_EX      (o_done_EX),
        .o_result_EX    (o_result_EX)
    );

    assign i_alu_result_EX = (o_alu_ctrl_EX == 5'b00011) ?
                             o_alu_a_EX + o_alu_b_EX : 32'h0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    endtask

    // Start an op, then count cycles until done (bounded).
    task automatic run_op(input logic [1:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input bit poke,
                          output int lat,
                          output int own_n,
                          output int ctl_n,
                          output int stl_n,
                          output int bnz,
                          output bit seen);
        @(negedge i_clk);
        i_start_EX = 1'b1;
        i_op_EX    = op;
        i_rs1_EX   = a;
        i_rs2_EX   = b;
        own_n = 0; ctl_n = 0; stl_n = 0; bnz = 0;
        @(posedge i_clk); #1;
        i_start_EX = 1'b0;
        lat = 1;
        while (!o_done_EX && lat < 100) begin
            if (o_alu_own_EX) own_n++;
            if (o_alu_ctrl_EX == 5'b00011) ctl_n++;
            if (o_stall_EX) stl_n++;
            if (o_alu_own_EX && o_alu_b_EX != 0) bnz++;
            if (poke && lat == 5) begin
                i_start_EX = 1'b1;
                i_rs1_EX   = 32'd9999;
                i_rs2_EX   = 32'd7777;
            end
            if (poke && lat == 8) i_start_EX = 1'b0;
            @(posedge i_clk); #1;
            lat++;
        end
        if (o_stall_EX) stl_n++;
        seen = o_done_EX;
    endtask

    // Watch a bounded window and report whether done ever pulsed.
    task automatic watch_done(input int cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge i_clk); #1;
            if (o_done_EX) seen = 1'b1;
        end
    endtask

    int lat, own_n, ctl_n, stl_n, bnz;
    bit seen;

    initial begin
        n_chk = 0; n_ok = 0;
        i_rst_n = 1'b0; i_start_EX = 1'b0; i_op_EX = 2'b00;
        i_rs1_EX = '0; i_rs2_EX = '0; i_flush_EX = 1'b0;
        #12;
        check("rst_result", o_result_EX, 32'h0);
        check("rst_done", 32'(o_done_EX), 32'h0);
        check("rst_own", 32'(o_alu_own_EX), 32'h0);
        check("rst_stall", 32'(o_stall_EX), 32'h0);
        check("rst_ctrl", 32'(o_alu_ctrl_EX), 32'h0);
        check("rst_a", o_alu_a_EX, 32'h0);
        check("rst_b", o_alu_b_EX, 32'h0);
        @(negedge i_clk); i_rst_n = 1'b1;

        run_op(2'b00, 32'd3, 32'd5, 1'b0, lat, own_n, ctl_n, stl_n, bnz, seen);
        check("mul3x5_done", 32'(seen), 32'h1);
        check("mul3x5_lat", 32'(lat), 32'd33);
        check("mul3x5_res", o_result_EX, 32'h0000000F);
        check("mul3x5_own", 32'(own_n), 32'd32);
        check("mul3x5_ctrl", 32'(ctl_n), 32'd32);
        check("mul3x5_stall", 32'(stl_n), 32'd33);
        @(posedge i_clk); #1;
        check("pulse_one", 32'(o_done_EX), 32'h0);
        check("post_stall", 32'(o_stall_EX), 32'h0);

        run_op(2'b10, 32'd3, 32'd5, 1'b0, lat, own_n, ctl_n, stl_n, bnz, seen);
        check("ill10_lat", 32'(lat), 32'd1);
        check("ill10_res", o_result_EX, 32'h0);
        check("ill10_own", 32'(own_n), 32'd0);
        @(posedge i_clk); #1;

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
               lat, own_n, ctl_n, stl_n, bnz, seen);
        check("mulff_lat", 32'(lat), 32'd33);
        check("mulff_res", o_result_EX, 32'h00000001);
        @(posedge i_clk); #1;

        run_op(2'b00, 32'h12345678, 32'h0, 1'b0,
               lat, own_n, ctl_n, stl_n, bnz, seen);
        check("mul0_res", o_result_EX, 32'h0);
        check("mul0_bzero", 32'(bnz), 32'd0);
        check("mul0_own", 32'(own_n), 32'd32);
        @(posedge i_clk); #1;

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
               lat, own_n, ctl_n, stl_n, bnz, seen);
`ifdef MULHU_EN
        check("mulhu_lat", 32'(lat), 32'd33);
        check("mulhu_res", o_result_EX, 32'hFFFFFFFE);
`else
        check("mulhu_lat", 32'(lat), 32'd1);
        check("mulhu_res", o_result_EX, 32'h0);
`endif
        @(posedge i_clk); #1;

        run_op(2'b00, 32'd100, 32'd200, 1'b1,
               lat, own_n, ctl_n, stl_n, bnz, seen);
        check("ign_lat", 32'(lat), 32'd33);
        check("ign_res", o_result_EX, 32'd20000);
        @(posedge i_clk); #1;

        // Flush at RUN cycle 10; result stays 20000.
        @(negedge i_clk);
        i_start_EX = 1'b1; i_op_EX = 2'b00;
        i_rs1_EX = 32'd7; i_rs2_EX = 32'd9;
        @(negedge i_clk); i_start_EX = 1'b0;
        repeat (9) @(negedge i_clk);
        check("fl_pre_own", 32'(o_alu_own_EX), 32'h1);
        i_flush_EX = 1'b1;
        @(posedge i_clk); #1;
        i_flush_EX = 1'b0;
        check("fl_own", 32'(o_alu_own_EX), 32'h0);
        check("fl_stall", 32'(o_stall_EX), 32'h0);
        check("fl_res", o_result_EX, 32'd20000);
        watch_done(40, seen);
        check("fl_nodone", 32'(seen), 32'h0);

        run_op(2'b00, 32'd6, 32'd7, 1'b0, lat, own_n, ctl_n, stl_n, bnz, seen);
        check("afl_lat", 32'(lat), 32'd33);
        check("afl_res", o_result_EX, 32'd42);
        @(posedge i_clk); #1;

        // Flush in IDLE blocks a same-cycle start.
        @(negedge i_clk);
        i_start_EX = 1'b1; i_flush_EX = 1'b1;
        i_rs1_EX = 32'd2; i_rs2_EX = 32'd2;
        @(posedge i_clk); #1;
        i_start_EX = 1'b0; i_flush_EX = 1'b0;
        check("idfl_stall", 32'(o_stall_EX), 32'h0);
        watch_done(40, seen);
        check("idfl_nodone", 32'(seen), 32'h0);

        // Reset at RUN cycle 20.
        @(negedge i_clk);
        i_start_EX = 1'b1; i_op_EX = 2'b00;
        i_rs1_EX = 32'h0000FFFF; i_rs2_EX = 32'hFFFFFFFF;
        @(negedge i_clk); i_start_EX = 1'b0;
        repeat (19) @(negedge i_clk);
        check("rr_pre_b", o_alu_b_EX, 32'h0000FFFF);
        #2 i_rst_n = 1'b0;
        #1;
        check("rr_own", 32'(o_alu_own_EX), 32'h0);
        check("rr_stall", 32'(o_stall_EX), 32'h0);
        check("rr_ctrl", 32'(o_alu_ctrl_EX), 32'h0);
        check("rr_a", o_alu_a_EX, 32'h0);
        check("rr_b", o_alu_b_EX, 32'h0);
        check("rr_res", o_result_EX, 32'h0);
        @(negedge i_clk); i_rst_n = 1'b1;
        watch_done(40, seen);
        check("rr_nodone", 32'(seen), 32'h0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Iterative shift-add multiplier controller in the execute stage. It borrows the shared ALU's ADD path for one accumulate per cycle and sequences the ALU across WIDTH iterations. It also drives the operand/control mux select that hands the ALU over from the pipeline, and stalls the pipeline while it owns the ALU. It delivers a 32-bit MUL result; MULHU is optional (see Configuration).

## Interface
Parameters:
- WIDTH, 32: operand/result width; must be a power of two ≥ 8.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start_EX  in  1  start request; sampled only in IDLE.
- i_op_EX  in  2  00 = MUL (low half), 01 = MULHU (high half, unsigned), 10/11 = reserved.
- i_rs1_EX  in  WIDTH  multiplicand; captured with start.
- i_rs2_EX  in  WIDTH  multiplier; captured with start.
- i_flush_EX  in  1  abort the current operation.
- i_alu_result_EX  in  WIDTH  result returned from the shared ALU.
- o_alu_ctrl_EX  out  5  ALU control code: ADD (5'b00011) in RUN, 5'b00000 otherwise.
- o_alu_a_EX  out  WIDTH  ALU operand A: acc_hi in RUN, else 0.
- o_alu_b_EX  out  WIDTH  ALU operand B: multiplicand if mplier[0], else 0; forced to 0 outside RUN.
- o_alu_own_EX  out  1  high in RUN; selects the sequencer's operands into the ALU.
- o_stall_EX  out  1  high in RUN and DONE; goes to the hazard unit.
- o_done_EX  out  1  one-cycle pulse; result valid.
- o_result_EX  out  WIDTH  product; held until the next accepted start.

## Operation
State machine: IDLE, RUN, DONE (2-bit encoding).

IDLE:
- i_start_EX=1 with a legal op:
  - capture mcand←rs1, mplier←rs2, acc_hi←0, op←i_op_EX, cnt←0.
  - go to RUN.
- i_start_EX=1 with an illegal op (10, 11, or 01 without the macro):
  - set o_result_EX←0, go to DONE.
  - No ALU ownership.

RUN, every cycle:
- Sum S = i_alu_result_EX (acc_hi + (mplier[0] ? mcand : 0)).
- carry = (S < o_alu_a_EX), unsigned compare, because the ALU has no carry-out.
- {acc_hi, mplier} ← {carry, S, mplier} >> 1.
  - mplier doubles as acc_lo; the product's low bits shift into it.
- cnt ← cnt+1.
- When cnt == WIDTH-1:
  - o_result_EX ← (op==MULHU) ? next acc_hi : next mplier.
  - go to DONE.
- cnt is $clog2(WIDTH) bits wide; wrap at WIDTH-1 is the terminal condition.

DONE:
- o_done_EX=1 for exactly this cycle.
- Go to IDLE unconditionally.

Flush:
- i_flush_EX in RUN or DONE → IDLE next edge.
- No o_done_EX, o_result_EX unchanged.
- Flush wins over the terminal count and over start.
- Flush in IDLE has no effect and blocks a same-cycle start.

Start outside IDLE is ignored; no queuing.

All arithmetic is unsigned modulo 2^WIDTH. Signed variants are out of scope.

## Timing
- Reset (async, immediate) values: state=IDLE, o_result_EX=0, o_done_EX=0, o_alu_own_EX=0, o_stall_EX=0, o_alu_ctrl_EX=5'b00000, o_alu_a_EX=0, o_alu_b_EX=0.
  - Internal mcand/mplier/acc_hi/cnt/op = 0.
- Reset mid-operation: abandon the operation; no done pulse after release.
- Legal-op latency: start sampled at edge T0; RUN for edges T1..T(WIDTH); o_done_EX high in the cycle after edge T(WIDTH).
  - Done is asserted WIDTH+1 cycles after start; next start is accepted WIDTH+2 cycles after start.
- Illegal-op latency: o_done_EX high one cycle after the start edge.
- ALU path is combinational (ALU out → i_alu_result_EX) inside one cycle. The sequencer adds no register on it.
- o_alu_* and o_stall_EX are decoded from registered state/data only (Moore); no input→output combinational paths.

## Configuration
- MULHU_EN defined:
  - op 01 is legal; o_result_EX returns acc_hi, the upper WIDTH bits of the unsigned 2·WIDTH product.
- MULHU_EN undefined:
  - op 01 is treated as illegal (result 0, 1-cycle done).
  - The op register and the high-half output mux are removed.
  - acc_hi and carry logic remain, because MUL still needs the full shift.

## Test plan
- MUL 3×5 → o_done_EX 33 cycles after start, o_result_EX=0x0000000F; o_alu_ctrl_EX=0x03 and o_alu_own_EX=1 for exactly 32 cycles.
- MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001. With MULHU_EN, MULHU on the same operands → 0xFFFFFFFE; without it → 0 after 1 cycle.
- MUL 0x12345678×0 → 0x00000000; o_alu_b_EX=0 in every RUN cycle.
- Flush at RUN cycle 10 → IDLE next cycle, no done pulse, o_result_EX keeps its previous value; a new start 1 cycle later completes normally.
- Start pulses during RUN (new operands) are ignored; the original product is returned.
- i_rst_n low at RUN cycle 20 → all outputs at reset values immediately; no done pulse after release.
